// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: fetch request/response, boot-load write port and mode control
// signals of instr_mem_ctrl. The slave modport is the memory side, master is the core side.
interface instr_mem_ctrl_if #(
   parameter int unsigned P_DATA_WIDTH = 32,
   parameter int unsigned P_ADDR_WIDTH = 12
);
   logic                    i_req_valid;
   logic [P_ADDR_WIDTH-1:0] i_req_addr;
   logic                    o_req_ready;
   logic                    o_rsp_valid;
   logic [P_DATA_WIDTH-1:0] o_rsp_instr;
   logic                    o_rsp_fault;
   logic                    o_rsp_perr;
   logic                    i_rsp_ready;
   logic                    i_flush;
   logic                    i_wr_en;
   logic [P_ADDR_WIDTH-1:0] i_wr_addr;
   logic [P_DATA_WIDTH-1:0] i_wr_data;
   logic                    i_boot_done;
   logic                    i_load_req;
   logic                    o_wr_err;
   logic [1:0]              o_state;

   modport slave (
      input  i_req_valid, i_req_addr, i_rsp_ready, i_flush, i_wr_en, i_wr_addr, i_wr_data,
             i_boot_done, i_load_req,
      output o_req_ready, o_rsp_valid, o_rsp_instr, o_rsp_fault, o_rsp_perr, o_wr_err, o_state
   );

   modport master (
      output i_req_valid, i_req_addr, i_rsp_ready, i_flush, i_wr_en, i_wr_addr, i_wr_data,
             i_boot_done, i_load_req,
      input  o_req_ready, o_rsp_valid, o_rsp_instr, o_rsp_fault, o_rsp_perr, o_wr_err, o_state
   );
endinterface

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: pipelined instruction memory with boot-load port, flush and fetch faults.
// Define IMEM_PARITY_EN to store and check an even-parity bit per word.
module instr_mem_ctrl #(
   parameter int unsigned P_DATA_WIDTH = 32,
   parameter int unsigned P_ADDR_WIDTH = 12,
   parameter int unsigned P_DEPTH      = 1024,
   parameter int unsigned P_LATENCY    = 1
) (
   input logic             i_clk,
   input logic             i_rst,
   instr_mem_ctrl_if.slave bus
);
   localparam int unsigned IdxW  = P_ADDR_WIDTH - 2;
   localparam int unsigned MemAw = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
   localparam int unsigned Last  = P_LATENCY - 1;
   localparam logic [P_DATA_WIDTH-1:0] Nop = P_DATA_WIDTH'(32'h0000_0013);

   typedef enum logic [1:0] {StLoad = 2'd0, StRun = 2'd1, StDrain = 2'd2} state_e;

   state_e                  state_q;
   logic                    wr_err_q;
   logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];

   logic [P_LATENCY-1:0]    vld_q, vld_d, fault_q, perr_q;
   logic [P_DATA_WIDTH-1:0] data_q [P_LATENCY];

   logic                    advance, accept, rd_ok, wr_ok, rd_perr;
   logic [IdxW-1:0]         rd_idx, wr_idx;
   logic [P_DATA_WIDTH-1:0] rd_word, rd_data;

   assign advance         = !vld_q[Last] || bus.i_rsp_ready;
   assign bus.o_req_ready = (state_q == StRun) && advance;
   assign accept          = bus.i_req_valid && bus.o_req_ready;

   assign rd_idx  = bus.i_req_addr[P_ADDR_WIDTH-1:2];
   assign wr_idx  = bus.i_wr_addr[P_ADDR_WIDTH-1:2];
   assign rd_ok   = (bus.i_req_addr[1:0] == 2'b00) && (32'(rd_idx) < P_DEPTH);
   assign wr_ok   = bus.i_wr_en && (state_q == StLoad) && (bus.i_wr_addr[1:0] == 2'b00) &&
                    (32'(wr_idx) < P_DEPTH);
   assign rd_word = mem[rd_idx[MemAw-1:0]];
   assign rd_data = rd_ok ? rd_word : Nop;

   // Storage is never reset; only the boot-load port writes it.
   always_ff @(posedge i_clk) begin
      if (wr_ok) mem[wr_idx[MemAw-1:0]] <= bus.i_wr_data;
   end

`ifdef IMEM_PARITY_EN
   logic par_mem [P_DEPTH];

   always_ff @(posedge i_clk) begin
      if (wr_ok) par_mem[wr_idx[MemAw-1:0]] <= ^bus.i_wr_data;
   end

   assign rd_perr = rd_ok && (par_mem[rd_idx[MemAw-1:0]] != ^rd_word);
`else
   assign rd_perr = 1'b0;
`endif

   // Next-cycle valids are also used by DRAIN, so it leaves as soon as the pipe empties.
   always_comb begin
      vld_d = vld_q;
      if (advance) begin
         for (int i = Last; i > 0; i--) vld_d[i] = vld_q[i-1];
         vld_d[0] = accept;
      end
      if (bus.i_flush) vld_d = P_LATENCY'(accept);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_q   <= '0;
         fault_q <= '0;
         perr_q  <= '0;
         for (int i = 0; i < P_LATENCY; i++) data_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         if (advance) begin
            for (int i = Last; i > 0; i--) begin
               data_q[i]  <= data_q[i-1];
               fault_q[i] <= fault_q[i-1];
               perr_q[i]  <= perr_q[i-1];
            end
            if (accept) begin
               data_q[0]  <= rd_data;
               fault_q[0] <= !rd_ok || rd_perr;
               perr_q[0]  <= rd_perr;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= StLoad;
         wr_err_q <= 1'b0;
      end else begin
         if (bus.i_wr_en && !wr_ok) wr_err_q <= 1'b1;
         unique case (state_q)
            StLoad:  if (bus.i_boot_done) state_q <= StRun;
            StRun:   if (bus.i_load_req) state_q <= StDrain;
            StDrain: if (vld_d == '0) state_q <= StLoad;
            default: state_q <= StLoad;
         endcase
      end
   end

   assign bus.o_rsp_valid = vld_q[Last];
   assign bus.o_rsp_instr = data_q[Last];
   assign bus.o_rsp_fault = fault_q[Last];
   assign bus.o_rsp_perr  = perr_q[Last];
   assign bus.o_wr_err    = wr_err_q;
   assign bus.o_state     = state_q;
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: directed bench for instr_mem_ctrl (13-bit addresses, 1024 words, latency 2).
// Define IMEM_PARITY_EN for the build to exercise the parity-error path.
module tb_instr_mem_ctrl;
   localparam int unsigned AW  = 13;
   localparam int unsigned LAT = 2;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0050_0093;
   localparam logic [31:0] I1  = 32'h00A0_0113;
   localparam logic [31:0] I2  = 32'h0000_0513;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   instr_mem_ctrl_if #(.P_DATA_WIDTH(32), .P_ADDR_WIDTH(AW)) bus ();

   instr_mem_ctrl #(
      .P_DATA_WIDTH(32),
      .P_ADDR_WIDTH(AW),
      .P_DEPTH     (1024),
      .P_LATENCY   (LAT)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic req(input logic v, input logic [AW-1:0] a);
      bus.i_req_valid = v;
      bus.i_req_addr  = a;
   endtask

   initial begin
      bus.i_req_valid = 1'b0;
      bus.i_req_addr  = '0;
      bus.i_rsp_ready = 1'b0;
      bus.i_flush     = 1'b0;
      bus.i_wr_en     = 1'b0;
      bus.i_wr_addr   = '0;
      bus.i_wr_data   = '0;
      bus.i_boot_done = 1'b0;
      bus.i_load_req  = 1'b0;

      repeat (2) tick();
      check("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
      check("rst_rsp_instr", bus.o_rsp_instr, 32'd0);
      check("rst_rsp_fault", 32'(bus.o_rsp_fault), 32'd0);
      check("rst_rsp_perr", 32'(bus.o_rsp_perr), 32'd0);
      check("rst_req_ready", 32'(bus.o_req_ready), 32'd0);
      check("rst_wr_err", 32'(bus.o_wr_err), 32'd0);
      check("rst_state", 32'(bus.o_state), 32'd0);
      rst = 1'b0;

      // Boot load; the third write coincides with i_boot_done.
      req(1'b1, 13'h0);
      check("load_req_ready", 32'(bus.o_req_ready), 32'd0);
      req(1'b0, 13'h0);
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 13'h0; bus.i_wr_data = I0;
      tick();
      bus.i_wr_addr = 13'h4; bus.i_wr_data = I1;
      tick();
      bus.i_wr_addr = 13'h8; bus.i_wr_data = I2; bus.i_boot_done = 1'b1;
      tick();
      bus.i_wr_en = 1'b0; bus.i_boot_done = 1'b0;
      check("boot_state_run", 32'(bus.o_state), 32'd1);
      check("boot_wr_err", 32'(bus.o_wr_err), 32'd0);

      // Back-to-back fetches of 0x0 and 0x4.
      bus.i_rsp_ready = 1'b1;
      req(1'b1, 13'h0);
      check("run_req_ready", 32'(bus.o_req_ready), 32'd1);
      tick();
      req(1'b1, 13'h4);
      tick();
      req(1'b0, 13'h0);
      check("b2b_valid0", 32'(bus.o_rsp_valid), 32'd1);
      check("b2b_instr0", bus.o_rsp_instr, I0);
      check("b2b_fault0", 32'(bus.o_rsp_fault), 32'd0);
      check("b2b_perr0", 32'(bus.o_rsp_perr), 32'd0);
      tick();
      check("b2b_valid1", 32'(bus.o_rsp_valid), 32'd1);
      check("b2b_instr1", bus.o_rsp_instr, I1);
      check("b2b_fault1", 32'(bus.o_rsp_fault), 32'd0);
      tick();
      check("b2b_idle", 32'(bus.o_rsp_valid), 32'd0);

      // Misaligned, then out-of-range fetch.
      req(1'b1, 13'h2);
      tick();
      req(1'b1, 13'h1000);
      tick();
      req(1'b0, 13'h0);
      check("misal_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("misal_instr", bus.o_rsp_instr, NOP);
      check("misal_fault", 32'(bus.o_rsp_fault), 32'd1);
      tick();
      check("oor_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("oor_instr", bus.o_rsp_instr, NOP);
      check("oor_fault", 32'(bus.o_rsp_fault), 32'd1);
      tick();
      check("fault_idle", 32'(bus.o_rsp_valid), 32'd0);

      // Stall three cycles with two fetches in flight.
      bus.i_rsp_ready = 1'b0;
      req(1'b1, 13'h0);
      tick();
      req(1'b1, 13'h4);
      tick();
      req(1'b0, 13'h0);
      for (int i = 0; i < 3; i++) begin
         check("stall_req_ready", 32'(bus.o_req_ready), 32'd0);
         check("stall_valid", 32'(bus.o_rsp_valid), 32'd1);
         check("stall_instr", bus.o_rsp_instr, I0);
         tick();
      end
      bus.i_rsp_ready = 1'b1;
      check("stall_rel_instr0", bus.o_rsp_instr, I0);
      tick();
      check("stall_rel_valid1", 32'(bus.o_rsp_valid), 32'd1);
      check("stall_rel_instr1", bus.o_rsp_instr, I1);
      tick();
      check("stall_idle", 32'(bus.o_rsp_valid), 32'd0);

      // Flush with two in flight while 0x4 is accepted in the same cycle.
      req(1'b1, 13'h0);
      tick();
      req(1'b1, 13'h8);
      tick();
      req(1'b1, 13'h4);
      bus.i_flush = 1'b1;
      check("flush_req_ready", 32'(bus.o_req_ready), 32'd1);
      tick();
      bus.i_flush = 1'b0;
      req(1'b0, 13'h0);
      check("flush_gap", 32'(bus.o_rsp_valid), 32'd0);
      tick();
      check("flush_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("flush_instr", bus.o_rsp_instr, I1);
      tick();
      check("flush_idle", 32'(bus.o_rsp_valid), 32'd0);

      // Write in RUN is dropped; then drain one fetch of 0x8 back to LOAD.
      bus.i_wr_en = 1'b1; bus.i_wr_addr = 13'h8; bus.i_wr_data = 32'hDEAD_BEEF;
      tick();
      bus.i_wr_en = 1'b0;
      check("run_wr_err", 32'(bus.o_wr_err), 32'd1);
      req(1'b1, 13'h8);
      bus.i_load_req = 1'b1;
      tick();
      req(1'b0, 13'h0);
      bus.i_load_req = 1'b0;
      check("drain_state0", 32'(bus.o_state), 32'd2);
      check("drain_req_ready", 32'(bus.o_req_ready), 32'd0);
      tick();
      check("drain_state1", 32'(bus.o_state), 32'd2);
      check("drain_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("drain_instr", bus.o_rsp_instr, I2);
      tick();
      check("drain_state_load", 32'(bus.o_state), 32'd0);
      check("drain_idle", 32'(bus.o_rsp_valid), 32'd0);
      check("wr_err_sticky", 32'(bus.o_wr_err), 32'd1);

      // Asynchronous reset with a response on the output; contents survive.
      bus.i_boot_done = 1'b1;
      tick();
      bus.i_boot_done = 1'b0;
      req(1'b1, 13'h4);
      tick();
      req(1'b0, 13'h0);
      tick();
      check("pre_rst_valid", 32'(bus.o_rsp_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", 32'(bus.o_rsp_valid), 32'd0);
      check("arst_instr", bus.o_rsp_instr, 32'd0);
      check("arst_state", 32'(bus.o_state), 32'd0);
      check("arst_wr_err", 32'(bus.o_wr_err), 32'd0);
      tick();
      rst = 1'b0;
      bus.i_boot_done = 1'b1;
      tick();
      bus.i_boot_done = 1'b0;
      req(1'b1, 13'h4);
      tick();
      req(1'b0, 13'h0);
      tick();
      check("persist_valid", 32'(bus.o_rsp_valid), 32'd1);
      check("persist_instr", bus.o_rsp_instr, I1);
      tick();

      // Word 0 fetch; with parity built, one data bit is flipped behind the parity bit.
`ifdef IMEM_PARITY_EN
      dut.mem[0] = dut.mem[0] ^ 32'h1;
`endif
      req(1'b1, 13'h0);
      tick();
      req(1'b0, 13'h0);
      tick();
      check("w0_valid", 32'(bus.o_rsp_valid), 32'd1);
`ifdef IMEM_PARITY_EN
      check("par_instr", bus.o_rsp_instr, I0 ^ 32'h1);
      check("par_perr", 32'(bus.o_rsp_perr), 32'd1);
      check("par_fault", 32'(bus.o_rsp_fault), 32'd1);
`else
      check("nopar_instr", bus.o_rsp_instr, I0);
      check("nopar_perr", 32'(bus.o_rsp_perr), 32'd0);
      check("nopar_fault", 32'(bus.o_rsp_fault), 32'd0);
`endif
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
